// File: rtl/roi_downsample.sv
// ROI crop + 8x8 box-filter downsampler: 224x224 window of the source frame -> 28x28 pixels,
// with guaranteed 784 outputs per accepted frame (zero padding on truncation).
module roi_downsample #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X0     = 208,
  parameter int Y0     = 128,
  parameter bit INVERT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       frame_start,
  input  logic [7:0] pix_in,
  input  logic       pix_in_valid,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       frame_done,
  output logic       abort_err
);

  localparam int ROI  = 224;
  localparam int BLKS = 28;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [9:0]    out_cnt;
  logic [13:0]   acc [BLKS];

  logic          starting;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          accept;
  logic          in_roi;
  logic [7:0]    rel_col;
  logic [7:0]    rel_row;
  logic [4:0]    blk;
  logic [13:0]   acc_cur;
  logic [13:0]   sum;
  logic          emit;

  // A frame start seen with pix_in_valid makes that pixel (0,0), so the
  // datapath looks at zeroed counters/accumulators in the starting cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    starting = 1'b0;
    if (frame_start && en)
      starting = (state == IDLE) || (state == RUN && out_cnt == 10'd0);
    cur_col = starting ? '0 : col;
    cur_row = starting ? '0 : row;
    accept  = pix_in_valid && (starting || (state == RUN && !frame_start))
              && (32'(cur_row) < IMG_H);
    in_roi  = accept
              && (32'(cur_col) >= X0) && (32'(cur_col) < X0 + ROI)
              && (32'(cur_row) >= Y0) && (32'(cur_row) < Y0 + ROI);
    rel_col = 8'(32'(cur_col) - 32'(X0));
    rel_row = 8'(32'(cur_row) - 32'(Y0));
    blk     = rel_col[7:3];
    acc_cur = starting ? '0 : acc[blk];
    sum     = acc_cur + 14'(pix_in);
    emit    = in_roi && !frame_start && (rel_row[2:0] == 3'd7) && (rel_col[2:0] == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      out_cnt        <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      abort_err      <= 1'b0;
      // NOTE: the accumulator bank is reset too, so a frame never starts from stale sums.
      for (int i = 0; i < BLKS; i++) acc[i] <= '0;
    end else begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      abort_err      <= 1'b0;

      // NOTE: non-blocking assignments; a later assignment in this block wins,
      // which lets the pixel update below override the start-of-frame clear.
      if (starting) begin
        state   <= RUN;
        col     <= '0;
        row     <= '0;
        out_cnt <= '0;
        for (int i = 0; i < BLKS; i++) acc[i] <= '0;
      end

      unique case (state)
        IDLE: ;
        RUN: begin
          if (frame_start) begin
            if (out_cnt != 10'd0) begin
              abort_err <= 1'b1;
              state     <= PAD;
            end else if (!en) begin
              state <= IDLE;
            end
          end else if (emit) begin
            data_out_valid <= 1'b1;
            data_out       <= INVERT ? ~sum[13:6] : sum[13:6];
            out_cnt        <= out_cnt + 10'd1;
            if (out_cnt == 10'd783) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        PAD: begin
          data_out_valid <= 1'b1;
          out_cnt        <= out_cnt + 10'd1;
          if (out_cnt == 10'd783) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (cur_col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
        end
        if (in_roi) acc[blk] <= emit ? 14'd0 : sum;
      end
    end
  end

endmodule

// File: doc/roi_downsample.md
# roi_downsample

Camera-side front end for the digit classifier. It takes the raw 8-bit grayscale pixel stream from the capture path, crops a fixed 224x224 region of interest, and averages each 8x8 block down to one pixel. It optionally inverts the result and emits exactly 784 pixels per frame (28x28, raster order) on `data_out`/`data_out_valid`, which connect directly to the classifier's `data_in`/`data_in_valid`. It guarantees frame alignment downstream: every started frame produces exactly 784 outputs, padding if the source frame is cut short.

## Interface
- `IMG_W`, 640, source pixels per line
- `IMG_H`, 480, source lines per frame
- `X0`, 208, ROI first column (ROI = columns X0..X0+223)
- `Y0`, 128, ROI first line (ROI = lines Y0..Y0+223)
- `INVERT`, 1, 1: output 255-avg (white digit on black); 0: output avg
- `clk` in 1 system clock
- `rst_n` in 1 reset; synchronous, active-low
- `en` in 1 frame accept enable, sampled only with `frame_start`
- `frame_start` in 1 one-cycle pulse marking start of a source frame
- `pix_in` in 8 source pixel
- `pix_in_valid` in 1 `pix_in` valid this cycle
- `data_out` out 8 downsampled pixel
- `data_out_valid` out 1 one-cycle strobe per output pixel
- `frame_done` out 1 one-cycle pulse with the 784th output of a frame
- `abort_err` out 1 one-cycle pulse when a frame is truncated

## Operation
- Counters:
  - `col` (0..IMG_W-1) advances on each accepted `pix_in_valid`. It wraps to 0 and increments `row`.
  - `row` saturates at IMG_H; pixels with `row`>=IMG_H are ignored.
  - `out_cnt` (0..784) counts emitted pixels.
- Accumulators: 28 x 14-bit, one per ROI block column. A pixel inside the ROI adds to `acc[(col-X0)>>3]`.
- On the 64th pixel of a block (ROI-relative line%8==7, column%8==7):
  - `sum = acc + pix_in`
  - output `sum[13:6]` (truncating divide by 64; max 16320 fits 14 bits), inverted if INVERT
  - `acc` clears to 0 in the same cycle.
- States:
  - IDLE: outputs silent, pixels ignored. `frame_start`&`en` goes to RUN; `frame_start`&!`en` is ignored (frame skipped).
  - RUN: accumulate/emit as above. Entering RUN clears `col`, `row`, `out_cnt` and all `acc`.
    - If `pix_in_valid` is high in the same cycle as `frame_start`, that pixel is pixel (0,0) of the new frame.
    - Emission with `out_cnt`==783 goes to IDLE and pulses `frame_done`.
    - `frame_start` with `out_cnt`==0 restarts RUN (re-clear, `en` re-sampled; `en` low goes to IDLE).
    - `frame_start` with `out_cnt`>0 pulses `abort_err` and goes to PAD.
  - PAD: emits `data_out`=0x00 every cycle, independent of INVERT, until `out_cnt` reaches 784. The last pad pulses `frame_done`, then the block goes to IDLE. `frame_start` and pixels are ignored during PAD, so the aborting frame is skipped.
- Simultaneous events: `frame_start` has priority over a pending block emission in the same cycle; that emission is discarded.

## Timing
- Reset (synchronous, `rst_n` low at a clk edge): state IDLE; `data_out`=0, `data_out_valid`=0, `frame_done`=0, `abort_err`=0; counters and accumulators 0. No padding is produced after reset mid-frame.
- Latency: `data_out_valid` is asserted one cycle after the clock edge that accepts the block's 64th pixel. All outputs are registered.
- RUN output spacing is at least 8 `pix_in_valid` cycles. Outputs come in bursts of 28 per block row, on ROI lines 7, 15, …, 223.
- PAD outputs are back-to-back, one per cycle. `abort_err` is asserted the cycle after the offending `frame_start`; the first pad follows one cycle later.
- No backpressure. Downstream must accept one pixel per cycle.

## Test plan
- Constant 0x80 full 640x480 frame, INVERT=0 -> 784 outputs all 0x80 in 28 bursts of 28. `frame_done` coincides with the 784th `data_out_valid`. State returns to IDLE.
- INVERT=1; ROI all 0x00 except block (0,0) all 0xFF; outside ROI all 0xFF -> first output 0x00, remaining 783 are 0xFF (outside-ROI pixels have no effect).
- Block (0,0) pixels = 0..63 raster, rest 0, INVERT=0 -> first output 31 (2016>>6), others 0.
- New `frame_start` after 300 outputs -> `abort_err` pulse, then 484 consecutive 0x00 outputs, then `frame_done`. The next `frame_start` yields a normal 784-pixel frame.
- `frame_start` with `en`=0 -> no outputs for the whole frame. A following frame with `en`=1 is processed normally.
- `rst_n` low for 1 cycle mid-RUN (out_cnt=100) -> all outputs 0 the next cycle, no pad, idle until the next `frame_start`.
